// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: pulses pll_reset, qualifies lock, releases sys_reset.
// Build option: define PLL_AUTO_RETRY_EN to re-pulse the PLL on lock timeout instead of failing.
module pll_reset_seq #(
    parameter int RST_PULSE_CYCLES    = 32,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 17
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       pll_ok,
    output logic       fail,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             bump;
    logic             lock_m;
    logic             lock_s;

    // pll_lock is asynchronous to clkin; nothing else looks at the raw pin
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_n = state;
        bump    = 1'b0;
        unique case (state)
            S_PLL_RST: begin
                if (cnt == RST_LAST)
                    state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = S_STABLE;
                end else if (cnt == TMO_LAST) begin
`ifdef PLL_AUTO_RETRY_EN
                    state_n = S_PLL_RST;
                    bump    = 1'b1;
`else
                    state_n = S_FAIL;
`endif
                end
            end
            S_STABLE: begin
                if (!lock_s)
                    state_n = S_WAIT_LOCK;
                else if (cnt == STB_LAST)
                    state_n = S_RUN;
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_n = S_PLL_RST;
                    bump    = 1'b1;
                end
            end
            S_FAIL: begin
                state_n = S_FAIL;
            end
            default: begin
                state_n = S_PLL_RST;
            end
        endcase
    end

    // outputs are decoded from the next state so they change with the state flop
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            pll_ok      <= 1'b0;
            fail        <= 1'b0;
            retry_count <= 4'd0;
        end else begin
            state <= state_n;
            if (state_n != state || state_n == S_RUN || state_n == S_FAIL)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            pll_reset <= (state_n == S_PLL_RST);
            sys_reset <= (state_n != S_RUN);
            pll_ok    <= (state_n == S_RUN);
            fail      <= (state_n == S_FAIL);
            if (bump && retry_count != 4'hF)
                retry_count <= retry_count + 4'd1;
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed table, corner sequences and random lock traffic.
// Expectations follow PLL_AUTO_RETRY_EN when it is defined for the build.
module tb_pll_reset_seq;

    localparam int RP = 4;
    localparam int SC = 8;
    localparam int TO = 32;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_reset;
    logic       pll_ok;
    logic       fail;
    logic [3:0] retry_count;

    int errors = 0;
    int checks = 0;

    pll_reset_seq #(
        .RST_PULSE_CYCLES   (RP),
        .LOCK_STABLE_CYCLES (SC),
        .LOCK_TIMEOUT_CYCLES(TO),
        .CNT_W              (6)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .sys_reset  (sys_reset),
        .pll_ok     (pll_ok),
        .fail       (fail),
        .retry_count(retry_count)
    );

    always #5 clkin = ~clkin;

    // Reference: phase plus cycles spent in it; lock seen two edges late.
    localparam int M_RST  = 0;
    localparam int M_WAIT = 1;
    localparam int M_STB  = 2;
    localparam int M_RUN  = 3;
    localparam int M_FAIL = 4;

    int   m_phase;
    int   m_age;
    int   m_retry;
    logic m_q[$];

    task automatic model_reset();
        m_phase = M_RST;
        m_age   = 0;
        m_retry = 0;
        m_q     = {1'b0, 1'b0};
    endtask

    task automatic model_edge(input logic l);
        logic ls;
        int   nxt;
        bit   again;
        ls = m_q.pop_front();
        m_q.push_back(l);
        nxt   = m_phase;
        again = 0;
        case (m_phase)
            M_RST:
                if (m_age + 1 == RP) nxt = M_WAIT;
            M_WAIT:
                if (ls) nxt = M_STB;
                else if (m_age + 1 == TO) begin
`ifdef PLL_AUTO_RETRY_EN
                    nxt   = M_RST;
                    again = 1;
`else
                    nxt = M_FAIL;
`endif
                end
            M_STB:
                if (!ls) nxt = M_WAIT;
                else if (m_age + 1 == SC) nxt = M_RUN;
            M_RUN:
                if (!ls) begin
                    nxt   = M_RST;
                    again = 1;
                end
            default: nxt = m_phase;
        endcase
        if (again && m_retry < 15) m_retry++;
        m_age   = (nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
    endtask

    function automatic logic [7:0] model_vec();
        return {m_phase == M_RST, m_phase != M_RUN, m_phase == M_RUN,
                m_phase == M_FAIL, 4'(m_retry)};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {pll_reset, sys_reset, pll_ok, fail, retry_count};
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got{prst,srst,ok,fail,retry}=%b exp=%b", nm, $time, got, exp);
        end
    endtask

    task automatic step(input logic l);
        pll_lock = l;
        @(posedge clkin);
        if (!reset) model_edge(l);
        @(negedge clkin);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic async_reset();
        #1 reset = 1'b1;
        #1 check("async_rst", dut_vec(), 8'b1100_0000);
        model_reset();
        @(posedge clkin);
        @(negedge clkin);
        check("rst_hold", dut_vec(), 8'b1100_0000);
        reset = 1'b0;
    endtask

    typedef struct {
        string      nm;
        logic       lock;
        int         n;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic l, int n, logic pr, logic sr,
                                logic ok, logic f, int r);
        vec_t v;
        v.nm   = nm;
        v.lock = l;
        v.n    = n;
        v.exp  = {pr, sr, ok, f, 4'(r)};
        return v;
    endfunction

    initial begin
        tbl.push_back(mk("pulse_hi",    0, 3,  1, 1, 0, 0, 0));
        tbl.push_back(mk("pulse_end",   0, 1,  0, 1, 0, 0, 0));
        tbl.push_back(mk("wait",        0, 6,  0, 1, 0, 0, 0));
        tbl.push_back(mk("qualify",     1, 10, 0, 1, 0, 0, 0));
        tbl.push_back(mk("release",     1, 1,  0, 0, 1, 0, 0));
        tbl.push_back(mk("run",         1, 5,  0, 0, 1, 0, 0));
        tbl.push_back(mk("loss_2e",     0, 2,  0, 0, 1, 0, 0));
        tbl.push_back(mk("loss_3e",     0, 1,  1, 1, 0, 0, 1));
        tbl.push_back(mk("repulse",     0, 3,  1, 1, 0, 0, 1));
        tbl.push_back(mk("repulse_end", 0, 1,  0, 1, 0, 0, 1));
        tbl.push_back(mk("relock",      1, 6,  0, 1, 0, 0, 1));
        tbl.push_back(mk("glitch",      0, 3,  0, 1, 0, 0, 1));
        tbl.push_back(mk("settle",      1, 10, 0, 1, 0, 0, 1));
        tbl.push_back(mk("rerelease",   1, 1,  0, 0, 1, 0, 1));
        tbl.push_back(mk("loss2",       0, 3,  1, 1, 0, 0, 2));
        tbl.push_back(mk("pre_tmo",     0, 35, 0, 1, 0, 0, 2));
`ifdef PLL_AUTO_RETRY_EN
        tbl.push_back(mk("tmo",         0, 1,  1, 1, 0, 0, 3));
        tbl.push_back(mk("late_lock",   1, 20, 0, 0, 1, 0, 3));
`else
        tbl.push_back(mk("tmo",         0, 1,  0, 1, 0, 1, 2));
        tbl.push_back(mk("late_lock",   1, 20, 0, 1, 0, 1, 2));
`endif

        reset    = 1'b1;
        pll_lock = 1'b0;
        model_reset();
        repeat (3) @(negedge clkin);
        check("reset", dut_vec(), 8'b1100_0000);
        reset = 1'b0;

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].lock);
            check(tbl[i].nm, dut_vec(), tbl[i].exp);
        end

        async_reset();
        for (int k = 0; k < 8; k++) step(1'b1);
        check("mid_stable", dut_vec(), 8'b0100_0000);
        async_reset();
        for (int k = 0; k < 20; k++) step(1'b1);
        check("mid_run", dut_vec(), 8'b0010_0000);
        async_reset();

        for (int k = 0; k < 600; k++) step(1'b0);
`ifdef PLL_AUTO_RETRY_EN
        check("saturate", {fail, retry_count}, 5'b0_1111);
`else
        check("fail_hold", dut_vec(), 8'b0101_0000);
`endif
        async_reset();

        for (int s = 0; s < 80; s++) begin
            logic l;
            int   len;
            l   = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 45);
            if ($urandom_range(0, 9) == 0) async_reset();
            for (int k = 0; k < len; k++) step(l);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Reset sequencer on the controlling side of the rPLL reset/lock interface.
- Runs on the free-running 27 MHz crystal clock.
- Drives the PLL `reset` input, watches its asynchronous `lock` output, and qualifies lock for a stable period.
- Releases the system reset (SDRAM controller, test logic) only after the PLL is stable; re-sequences the PLL on timeout or lock loss.

Parameters:
- RST_PULSE_CYCLES, 32: cycles pll_reset is held high per PLL reset pulse (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release (>=1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles to wait for lock after a pulse before timeout (>=2).
- CNT_W, 17: shared counter width; must hold max(params)-1.

Ports:
- clkin  input  1  27 MHz crystal clock, sole clock.
- reset  input  1  asynchronous, active-high block reset.
- pll_lock  input  1  PLL lock, asynchronous to clkin.
- pll_reset  output  1  to PLL reset input, active-high.
- sys_reset  output  1  system reset, active-high, deasserted synchronously to clkin.
- pll_ok  output  1  high only in RUN.
- fail  output  1  high only in FAIL (see Optional Feature).
- retry_count  output  4  number of re-sequences since reset, saturating at 15.

Behaviour:
- Clocking/reset: single clock clkin; reset asynchronous active-high.
- Reset values: state=PLL_RST, cnt=0, pll_reset=1, sys_reset=1, pll_ok=0, fail=0, retry_count=0, sync flops=0.
- Reset mid-operation: returns to the reset values immediately, from any state.
- Synchronizer: pll_lock passes through 2 flops to give lock_s. No other logic uses raw pll_lock.
- Outputs: all registered and decoded from state; no combinational path from input to output.
  - pll_reset=1 only in PLL_RST.
  - sys_reset=0 only in RUN.
- Counter: single counter cnt, zeroed on every state change.
- PLL_RST:
  - cnt increments each cycle.
  - When cnt==RST_PULSE_CYCLES-1: go to WAIT_LOCK.
  - pll_reset is high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - If lock_s=1: go to STABLE.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1: timeout, handled per Optional Feature.
  - Else cnt++.
  - When lock_s=1 and timeout occur on the same cycle, lock wins.
- STABLE:
  - If lock_s=0: go to WAIT_LOCK. This is a glitch case: retry_count is not incremented and the timeout window restarts.
  - Else if cnt==LOCK_STABLE_CYCLES-1: go to RUN.
  - Else cnt++.
- RUN:
  - pll_ok=1, sys_reset=0.
  - If lock_s=0: go to PLL_RST and retry_count++.
  - sys_reset reasserts on that same edge, i.e. 3 edges after pll_lock falls.
- FAIL (terminal): pll_reset=0, sys_reset=1, fail=1. Left only via reset.
- Release latency: pll_lock rising before edge E0 gives sys_reset low at edge E(LOCK_STABLE_CYCLES+2). This assumes lock_s stays high throughout.
- retry_count: saturates at 15 and does not wrap.

Optional Feature:
- Macro: PLL_AUTO_RETRY_EN.
- Defined: a WAIT_LOCK timeout goes to PLL_RST with retry_count++. FAIL is unreachable and fail stays 0.
- Undefined: a WAIT_LOCK timeout goes to FAIL.
- Lock loss in RUN re-sequences to PLL_RST in both builds.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
1. Reset, then pll_lock driven high 10 cycles after reset release -> pll_reset high exactly 4 cycles; sys_reset falls 10 edges after the first sampling edge of pll_lock; pll_ok=1; retry_count=0.
2. pll_lock 3-cycle low glitch during STABLE -> returns to WAIT_LOCK; sys_reset stays high; after lock is steady, release occurs 10 edges later; retry_count=0.
3. pll_lock falls in RUN -> sys_reset=1 and pll_ok=0 on the 3rd edge; new 4-cycle pll_reset pulse; retry_count=1.
4. pll_lock held low, PLL_AUTO_RETRY_EN defined -> pll_reset pulses every 36 cycles; retry_count reaches 15 and holds; fail=0.
5. pll_lock held low, macro undefined -> after 4+32 cycles fail=1, pll_reset=0, sys_reset=1 permanently; a later pll_lock high is ignored.
6. reset asserted asynchronously mid-STABLE and mid-RUN -> outputs return to the reset values without waiting for a clkin edge; the sequence restarts at PLL_RST.
